// File: rtl/rect_raster_pkg.sv
// Shared types and defaults for the rectangle rasterizer.
package rect_raster_pkg;

    localparam int unsigned FRAME_W_DEF = 320;
    localparam int unsigned FRAME_H_DEF = 240;
    localparam int unsigned COORD_W     = 10;

    // One filled-rectangle command; corners are inclusive.
    typedef struct packed {
        logic [COORD_W-1:0] x0;
        logic [COORD_W-1:0] y0;
        logic [COORD_W-1:0] x1;
        logic [COORD_W-1:0] y1;
        logic [3:0]         color;
    } rect_cmd_t;

    // Render FSM states.
    typedef logic [1:0] rast_state_t;
    localparam rast_state_t StDone  = 2'd0;
    localparam rast_state_t StClear = 2'd1;
    localparam rast_state_t StFetch = 2'd2;
    localparam rast_state_t StDraw  = 2'd3;

    // Saturate a coordinate at the last visible index.
    function automatic logic [COORD_W-1:0] clamp_coord(input logic [COORD_W-1:0] v,
                                                       input logic [COORD_W-1:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/rect_cmd_fifo.sv
// Synchronous FIFO holding pending rectangle commands; pop data is the head entry.
module rect_cmd_fifo
    import rect_raster_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic      clk_i,
    input  logic      reset_i,
    input  logic      push_i,
    input  rect_cmd_t push_data_i,
    input  logic      pop_i,
    output rect_cmd_t pop_data_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    rect_cmd_t        mem_q [DEPTH];
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty_o    = (wr_ptr_q == rd_ptr_q);
    assign full_o     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign pop_data_o = mem_q[rd_ptr_q[PTR_W-1:0]];

    // Pointer advance; push and pop may coincide.
    always_comb begin
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        wr_ptr_d = do_push ? wr_ptr_q + (PTR_W+1)'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + (PTR_W+1)'(1) : rd_ptr_q;
    end

    // Pointer registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents need no reset.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/rect_rasterizer.sv
// Frame renderer: clears the back buffer, then draws queued rectangles one pixel per clock.
// Optional macro RECT_RASTER_CLIP_EN: clamp off-screen corners instead of discarding the command.
module rect_rasterizer
    import rect_raster_pkg::*;
#(
    parameter int unsigned FRAME_W    = FRAME_W_DEF,
    parameter int unsigned FRAME_H    = FRAME_H_DEF,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [3:0]  BG_COLOR   = 4'h0
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       gpu_start,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [9:0] cmd_x0,
    input  logic [9:0] cmd_y0,
    input  logic [9:0] cmd_x1,
    input  logic [9:0] cmd_y1,
    input  logic [3:0] cmd_color,
    output logic [9:0] gpu_x,
    output logic [9:0] gpu_y,
    output logic [3:0] gpu_data,
    output logic       gpu_we,
    output logic       gpu_done
);

    localparam logic [9:0] X_LAST = 10'(FRAME_W - 1);
    localparam logic [9:0] Y_LAST = 10'(FRAME_H - 1);

    logic        start_meta_q, start_sync_q, start_prev_q;
    logic        start_edge;
    rast_state_t state_q, state_d;
    logic [9:0]  x_q, x_d, y_q, y_d;
    rect_cmd_t   cmd_q, cmd_d;
    logic [9:0]  gpu_x_q, gpu_x_d, gpu_y_q, gpu_y_d;
    logic [3:0]  gpu_data_q, gpu_data_d;
    logic        gpu_we_q, gpu_we_d, gpu_done_q, gpu_done_d;
    logic        fifo_full, fifo_empty, fifo_pop;
    rect_cmd_t   fifo_head, fetch_cmd, push_cmd;
    logic        fetch_ok;

    assign push_cmd  = '{x0: cmd_x0, y0: cmd_y0, x1: cmd_x1, y1: cmd_y1, color: cmd_color};
    assign cmd_ready = !fifo_full;

    rect_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (Clk),
        .reset_i     (Reset),
        .push_i      (cmd_valid && cmd_ready),
        .push_data_i (push_cmd),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // gpu_start comes from another domain: two-flop synchroniser plus edge history.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            start_meta_q <= 1'b0;
            start_sync_q <= 1'b0;
            start_prev_q <= 1'b0;
        end else begin
            start_meta_q <= gpu_start;
            start_sync_q <= start_meta_q;
            start_prev_q <= start_sync_q;
        end
    end

    assign start_edge = start_sync_q && !start_prev_q;

    // Head-of-queue command as it will be drawn, and whether it produces any pixels.
    always_comb begin
`ifdef RECT_RASTER_CLIP_EN
        fetch_cmd       = fifo_head;
        fetch_cmd.x0    = clamp_coord(fifo_head.x0, X_LAST);
        fetch_cmd.x1    = clamp_coord(fifo_head.x1, X_LAST);
        fetch_cmd.y0    = clamp_coord(fifo_head.y0, Y_LAST);
        fetch_cmd.y1    = clamp_coord(fifo_head.y1, Y_LAST);
        fetch_ok        = (fetch_cmd.x1 >= fetch_cmd.x0) && (fetch_cmd.y1 >= fetch_cmd.y0);
`else
        fetch_cmd       = fifo_head;
        fetch_ok        = (fifo_head.x0 <= X_LAST) && (fifo_head.x1 <= X_LAST) &&
                          (fifo_head.y0 <= Y_LAST) && (fifo_head.y1 <= Y_LAST) &&
                          (fifo_head.x1 >= fifo_head.x0) && (fifo_head.y1 >= fifo_head.y0);
`endif
    end

    // FSM next state, sweep counters and registered pixel outputs.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        cmd_d      = cmd_q;
        fifo_pop   = 1'b0;
        gpu_x_d    = gpu_x_q;
        gpu_y_d    = gpu_y_q;
        gpu_data_d = gpu_data_q;
        gpu_we_d   = 1'b0;
        gpu_done_d = gpu_done_q;
        case (state_q)
            StDone: begin
                gpu_done_d = 1'b1;
                if (start_edge) begin
                    state_d    = StClear;
                    x_d        = '0;
                    y_d        = '0;
                    gpu_done_d = 1'b0;
                end
            end
            StClear: begin
                gpu_x_d    = x_q;
                gpu_y_d    = y_q;
                gpu_data_d = BG_COLOR;
                gpu_we_d   = 1'b1;
                if (x_q == X_LAST) begin
                    x_d = '0;
                    if (y_q == Y_LAST) begin
                        state_d = StFetch;
                    end else begin
                        y_d = y_q + 10'd1;
                    end
                end else begin
                    x_d = x_q + 10'd1;
                end
            end
            StFetch: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    cmd_d    = fetch_cmd;
                    // Empty commands are dropped here and the next one is fetched.
                    if (fetch_ok) begin
                        state_d = StDraw;
                        x_d     = fetch_cmd.x0;
                        y_d     = fetch_cmd.y0;
                    end
                end else begin
                    state_d    = StDone;
                    gpu_done_d = 1'b1;
                end
            end
            StDraw: begin
                gpu_x_d    = x_q;
                gpu_y_d    = y_q;
                gpu_data_d = cmd_q.color;
                gpu_we_d   = 1'b1;
                if (x_q == cmd_q.x1) begin
                    x_d = cmd_q.x0;
                    if (y_q == cmd_q.y1) begin
                        state_d = StFetch;
                    end else begin
                        y_d = y_q + 10'd1;
                    end
                end else begin
                    x_d = x_q + 10'd1;
                end
            end
            default: begin
                state_d = StDone;
            end
        endcase
    end

    // State and output registers; reset also aborts a frame in progress.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= StDone;
            x_q        <= '0;
            y_q        <= '0;
            cmd_q      <= '0;
            gpu_x_q    <= '0;
            gpu_y_q    <= '0;
            gpu_data_q <= '0;
            gpu_we_q   <= 1'b0;
            gpu_done_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            cmd_q      <= cmd_d;
            gpu_x_q    <= gpu_x_d;
            gpu_y_q    <= gpu_y_d;
            gpu_data_q <= gpu_data_d;
            gpu_we_q   <= gpu_we_d;
            gpu_done_q <= gpu_done_d;
        end
    end

    assign gpu_x    = gpu_x_q;
    assign gpu_y    = gpu_y_q;
    assign gpu_data = gpu_data_q;
    assign gpu_we   = gpu_we_q;
    assign gpu_done = gpu_done_q;

endmodule

// File: tb/tb_rect_rasterizer.sv
// Directed bench for rect_rasterizer with a pixel scoreboard; uses a reduced 32x24 frame.
module tb_rect_rasterizer;

    localparam int W     = 32;
    localparam int H     = 24;
    localparam int N     = W * H;
    localparam int LIMIT = 5000;
    localparam logic [3:0] BG = 4'h0;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [3:0] d;
    } pix_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       gpu_start;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [9:0] cmd_x0, cmd_y0, cmd_x1, cmd_y1;
    logic [3:0] cmd_color;
    logic [9:0] gpu_x, gpu_y;
    logic [3:0] gpu_data;
    logic       gpu_we, gpu_done;

    int   checks = 0;
    int   errors = 0;
    int   low_total = 0;
    int   wr_total = 0;
    pix_t sb[$];

    always #5 clk = ~clk;

    rect_rasterizer #(
        .FRAME_W    (W),
        .FRAME_H    (H),
        .FIFO_DEPTH (8),
        .BG_COLOR   (BG)
    ) dut (
        .Clk       (clk),
        .Reset     (reset),
        .gpu_start (gpu_start),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x0    (cmd_x0),
        .cmd_y0    (cmd_y0),
        .cmd_x1    (cmd_x1),
        .cmd_y1    (cmd_y1),
        .cmd_color (cmd_color),
        .gpu_x     (gpu_x),
        .gpu_y     (gpu_y),
        .gpu_data  (gpu_data),
        .gpu_we    (gpu_we),
        .gpu_done  (gpu_done)
    );

    // Pixel monitor: every write must match the head of the scoreboard.
    always @(negedge clk) begin
        pix_t obs, exp_pix;
        if (gpu_done === 1'b0) low_total++;
        if (gpu_we === 1'b1) begin
            wr_total++;
            checks++;
            obs = {gpu_x, gpu_y, gpu_data};
            if (sb.size() == 0) begin
                errors++;
                $error("FAIL unexpected_write: observed (%0d,%0d)=%0h expected no write",
                       gpu_x, gpu_y, gpu_data);
            end else begin
                exp_pix = sb.pop_front();
                assert (obs === exp_pix) else begin
                    errors++;
                    $error("FAIL pixel: observed (%0d,%0d)=%0h expected (%0d,%0d)=%0h",
                           obs.x, obs.y, obs.d, exp_pix.x, exp_pix.y, exp_pix.d);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic expect_clear();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                sb.push_back({10'(x), 10'(y), BG});
    endtask

    // Reference model of one command's pixels; returns the number of writes expected.
    task automatic expect_rect(input int x0, input int y0, input int x1, input int y1,
                               input int c, output int npix);
        int ax0 = x0, ay0 = y0, ax1 = x1, ay1 = y1;
        npix = 0;
`ifdef RECT_RASTER_CLIP_EN
        if (ax0 > W - 1) ax0 = W - 1;
        if (ax1 > W - 1) ax1 = W - 1;
        if (ay0 > H - 1) ay0 = H - 1;
        if (ay1 > H - 1) ay1 = H - 1;
`else
        if (x0 >= W || x1 >= W || y0 >= H || y1 >= H) return;
`endif
        if (ax1 < ax0 || ay1 < ay0) return;
        for (int y = ay0; y <= ay1; y++)
            for (int x = ax0; x <= ax1; x++) begin
                sb.push_back({10'(x), 10'(y), 4'(c)});
                npix++;
            end
    endtask

    task automatic push_cmd(input int x0, input int y0, input int x1, input int y1,
                            input int c, output int waited);
        cmd_x0 = 10'(x0); cmd_y0 = 10'(y0); cmd_x1 = 10'(x1); cmd_y1 = 10'(y1);
        cmd_color = 4'(c);
        cmd_valid = 1'b1;
        waited = 0;
        while (!cmd_ready && waited < LIMIT) begin
            tick(1);
            waited++;
        end
        if (waited >= LIMIT) check("push_timeout", 32'(cmd_ready), 32'd1);
        tick(1);
        cmd_valid = 1'b0;
    endtask

    task automatic start_frame(input string tag);
        int cnt = 0;
        gpu_start = 1'b1;
        while (gpu_done && cnt < 20) begin
            tick(1);
            cnt++;
        end
        check({tag, "_done_fell"}, 32'(gpu_done), 32'd0);
        gpu_start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int cnt = 0;
        while (!gpu_done && cnt < LIMIT) begin
            tick(1);
            cnt++;
        end
        check({tag, "_done_rose"}, 32'(gpu_done), 32'd1);
    endtask

    task automatic finish_checks(input string tag, input int low0, input int wr0,
                                 input int ncmd, input int npix);
        check({tag, "_busy_cycles"}, 32'(low_total - low0), 32'(N + 1 + ncmd + npix));
        check({tag, "_writes"}, 32'(wr_total - wr0), 32'(N + npix));
        check({tag, "_sb_left"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int  low0, wr0, npix, n, waited, cnt;
        bit  idle_ok;

        reset = 1'b1; gpu_start = 1'b0; cmd_valid = 1'b0;
        cmd_x0 = '0; cmd_y0 = '0; cmd_x1 = '0; cmd_y1 = '0; cmd_color = '0;
        tick(3);
        check("rst_we", 32'(gpu_we), 32'd0);
        check("rst_done", 32'(gpu_done), 32'd1);
        check("rst_xy_data", {8'd0, gpu_x, gpu_y, gpu_data}, 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        reset = 1'b0;

        // Idle with no start: nothing happens.
        idle_ok = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if (gpu_we !== 1'b0 || gpu_done !== 1'b1 || cmd_ready !== 1'b1) idle_ok = 1'b0;
        end
        check("idle_quiet", 32'(idle_ok), 32'd1);

        // Frame with empty queue: clear only.
        low0 = low_total; wr0 = wr_total;
        expect_clear();
        start_frame("clear_only");
        wait_done("clear_only");
        finish_checks("clear_only", low0, wr0, 0, 0);
        check("clear_only_we_after", 32'(gpu_we), 32'd0);

        // Single small rectangle.
        low0 = low_total; wr0 = wr_total;
        push_cmd(10, 20, 12, 21, 5, waited);
        check("one_cmd_ready", 32'(cmd_ready), 32'd1);
        expect_clear();
        expect_rect(10, 20, 12, 21, 5, npix);
        start_frame("rect");
        wait_done("rect");
        finish_checks("rect", low0, wr0, 1, npix);

        // Fill the queue; the ninth command waits for the first pop.
        low0 = low_total; wr0 = wr_total;
        expect_clear();
        n = 0;
        for (int i = 0; i < 9; i++) begin
            expect_rect(2 * i, 3, 2 * i + 1, 3, i + 1, npix);
            n += npix;
        end
        for (int i = 0; i < 8; i++) begin
            if (i == 7) check("ready_before_8th", 32'(cmd_ready), 32'd1);
            push_cmd(2 * i, 3, 2 * i + 1, 3, i + 1, waited);
        end
        check("full_after_8th", 32'(cmd_ready), 32'd0);
        gpu_start = 1'b1;
        push_cmd(16, 3, 17, 3, 9, waited);
        check("ninth_held_through_clear", 32'(waited > N), 32'd1);
        gpu_start = 1'b0;
        wait_done("full_queue");
        finish_checks("full_queue", low0, wr0, 9, n);

        // Inverted and off-screen commands; a start edge during clear must be ignored.
        low0 = low_total; wr0 = wr_total;
        push_cmd(5, 5, 4, 9, 3, waited);
        push_cmd(22, 14, 42, 34, 7, waited);
        expect_clear();
        expect_rect(5, 5, 4, 9, 3, npix);
        check("inverted_model_zero", 32'(npix), 32'd0);
        n = npix;
        expect_rect(22, 14, 42, 34, 7, npix);
`ifdef RECT_RASTER_CLIP_EN
        check("offscreen_model", 32'(npix), 32'd100);
`else
        check("offscreen_model", 32'(npix), 32'd0);
`endif
        n += npix;
        start_frame("edge_cases");
        tick(10);
        gpu_start = 1'b1;
        tick(5);
        gpu_start = 1'b0;
        wait_done("edge_cases");
        finish_checks("edge_cases", low0, wr0, 2, n);
        wr0 = wr_total;
        idle_ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (gpu_done !== 1'b1) idle_ok = 1'b0;
        end
        check("ignored_edge_no_frame", 32'(idle_ok), 32'd1);
        check("ignored_edge_no_writes", 32'(wr_total - wr0), 32'd0);

        // Reset in the middle of a draw with a command still queued.
        wr0 = wr_total;
        push_cmd(0, 0, 31, 23, 9, waited);
        push_cmd(1, 1, 2, 2, 4, waited);
        expect_clear();
        expect_rect(0, 0, 31, 23, 9, npix);
        expect_rect(1, 1, 2, 2, 4, npix);
        start_frame("mid_draw");
        cnt = 0;
        while (wr_total - wr0 < N + 10 && cnt < LIMIT) begin
            tick(1);
            cnt++;
        end
        check("mid_draw_reached", 32'(wr_total - wr0 >= N + 10), 32'd1);
        reset = 1'b1;
        tick(1);
        check("mid_rst_we", 32'(gpu_we), 32'd0);
        check("mid_rst_done", 32'(gpu_done), 32'd1);
        check("mid_rst_xy_data", {8'd0, gpu_x, gpu_y, gpu_data}, 32'd0);
        check("mid_rst_ready", 32'(cmd_ready), 32'd1);
        reset = 1'b0;
        sb.delete();
        wr0 = wr_total;
        tick(20);
        check("mid_rst_quiet", 32'(wr_total - wr0), 32'd0);

        // Queue must have been emptied by reset: next frame is clear only.
        low0 = low_total; wr0 = wr_total;
        expect_clear();
        start_frame("after_reset");
        wait_done("after_reset");
        finish_checks("after_reset", low0, wr0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rect_rasterizer.md
Name: rect_rasterizer

Overview:
Render engine on the GPU clock. It produces the pixel write stream (gpu_x, gpu_y, gpu_data, gpu_we) and the gpu_done flag consumed by the double-buffered frame director, and it reacts to that director's gpu_start. On each start it clears the back buffer to a background colour, then drains a queue of filled-rectangle commands, one pixel per clock, then raises done.

Parameters:
FRAME_W, 320, frame width in pixels
FRAME_H, 240, frame height in pixels
FIFO_DEPTH, 8, rectangle command queue depth (power of 2)
BG_COLOR, 4'h0, clear colour written during CLEAR

Ports:
Clk  in  1  GPU clock (150 MHz domain)
Reset  in  1  synchronous, active-high reset
gpu_start  in  1  start request from frame director; level held until gpu_done falls; may change asynchronously to Clk
cmd_valid  in  1  rectangle command valid
cmd_ready  out  1  queue can accept a command (FIFO not full)
cmd_x0, cmd_y0, cmd_x1, cmd_y1  in  10 each  inclusive rectangle corners
cmd_color  in  4  rectangle fill intensity
gpu_x, gpu_y  out  10 each  pixel coordinate being written
gpu_data  out  4  pixel value
gpu_we  out  1  pixel write strobe
gpu_done  out  1  frame rendered; back buffer stable

Behaviour:
- Clk and Reset: one clock; reset is synchronous and active-high.
- Reset: gpu_x=0, gpu_y=0, gpu_data=0, gpu_we=0, gpu_done=1, FIFO emptied, state DONE. A reset asserted mid-frame aborts on the next edge with the same values.
- gpu_start synchronisation: 2-flop synchroniser, then a rising-edge detector.
- A start edge is honoured only in DONE. Edges in any other state are dropped.
- Command acceptance: a push occurs on cmd_valid && cmd_ready in any state. cmd_ready = !full. A push to a full FIFO is impossible by construction.
- States:
  - DONE: gpu_done=1, gpu_we=0. Start edge -> CLEAR, with gpu_done=0 on the next cycle.
  - CLEAR: raster sweep with x fastest, (0,0)..(FRAME_W-1,FRAME_H-1). Writes one BG_COLOR pixel per cycle with gpu_we=1. After the last pixel -> FETCH. Duration is exactly FRAME_W*FRAME_H cycles (76800).
  - FETCH (1 cycle, gpu_we=0): if the FIFO is non-empty, pop and latch the command -> DRAW; otherwise -> DONE.
  - DRAW: sweep x0..x1 inner, y0..y1 outer, with gpu_data=color and gpu_we=1. After (x1,y1) -> FETCH. A command with x1<x0 or y1<y0 writes nothing: FETCH goes back to FETCH.
- Commands pushed during CLEAR or DRAW are drawn in the same frame if they are present at a FETCH.
- Output timing: all outputs are registered. The first write appears the cycle after the state entry.
- Throughput: one pixel per cycle, plus 1 idle cycle per command.
- Pop and push in the same cycle are both allowed; the count is unchanged.
- Out-of-range handling (coordinate ≥ FRAME_W/H): see Optional Feature.

Optional Feature:
Macro RECT_RASTER_CLIP_EN.
- Defined: x0/x1 are clamped to FRAME_W-1 and y0/y1 to FRAME_H-1 at FETCH. A partially off-screen rectangle draws only its visible part.
- Undefined: any command with a corner outside the frame is discarded at FETCH (zero writes), so gpu_x/gpu_y never leave the frame.

Decomposition:
- Package rect_raster_pkg holds:
  - FRAME_W/FRAME_H defaults
  - rect_cmd_t packed struct {x0,y0,x1,y1 [9:0]; color [3:0]}
  - state enum {DONE, CLEAR, FETCH, DRAW}
- Sub-module rect_cmd_fifo: synchronous FIFO of rect_cmd_t, depth FIFO_DEPTH, with full/empty outputs.

Test Plan:
- Reset, then hold gpu_start=0 -> gpu_done=1, gpu_we=0, cmd_ready=1 indefinitely.
- Empty FIFO, pulse gpu_start -> gpu_done falls; exactly 76800 writes of 4'h0 in raster order ending at (319,239); one FETCH cycle; gpu_done=1.
- Queue (10,20)-(12,21) color 5, then start -> after the clear, 6 writes: (10,20),(11,20),(12,20),(10,21),(11,21),(12,21), all data 5; then done.
- Push 9 commands without start -> cmd_ready=0 after the 8th; the 9th is held until the first pop after start.
- Inverted rect (5,5)-(4,9) plus an off-screen rect (310,230)-(330,250) -> the inverted rect gives 0 writes. With the macro, the off-screen rect gives 100 writes covering (310..319, 230..239); without it, 0 writes.
- Start edge during CLEAR is ignored; Reset asserted mid-DRAW -> next cycle gpu_we=0, gpu_done=1, FIFO empty.
